vector_floating_point_sign_injection_sequencer: RTL

VECTOR_FLOATING_POINT_SIGN_INJECTION_SEQUENCER -- requirements
Module: vector_floating_point_sign_injection_sequencer

---
 rtl/vector_floating_point_sign_injection_sequencer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/vector_floating_point_sign_injection_sequencer.sv
// Vector floating-point sign-injection sequencer.
// Accepts one vector instruction at a time. It walks the operand register
// file one 64-bit beat per cycle and writes the sign-injected results back.
// Ports:
//   clk, rst                       clock, async active-high reset
//   req_valid/req_ready            instruction handshake
//   req_execution_vector           sign_injection_mode + bit_mode
//   req_vs2/vs1/vd_base, req_vl    operand base beat addresses, element count
//   rf_rd_*                        read strobe/addresses; data returns a cycle later
//   rf_wr_*                        write strobe/address/data/32-bit lane mask
//   busy, done, done_error         status; done_error qualifies done

package vfp_sgnj_pkg;
  localparam logic [1:0] SGNJ_VS1 = 2'd0;  // take sign of vs1
  localparam logic [1:0] SGNJ_NEG = 2'd1;  // take inverted sign of vs1
  localparam logic [1:0] SGNJ_XOR = 2'd2;  // sign(vs2) ^ sign(vs1)
  localparam logic [1:0] BM_32    = 2'd1;  // two fp32 lanes per beat
  localparam logic [1:0] BM_64    = 2'd2;  // one fp64 element per beat

  typedef struct packed {
    logic [1:0] sign_injection_mode;
    logic [1:0] bit_mode;
  } execution_vector_t;
endpackage

// Combinational sign injection on one 64-bit beat. vd keeps vs2's magnitude
// and exponent and replaces only the sign bit(s).
module vector_floating_point_sign_injection_unit
  import vfp_sgnj_pkg::*;
(
  input  execution_vector_t execution_vector,
  input  logic [63:0]       vs2,
  input  logic [63:0]       vs1,
  output logic [63:0]       vd
);
  function automatic logic inj(input logic [1:0] mode, input logic s2, input logic s1);
    case (mode)
      SGNJ_VS1: inj = s1;
      SGNJ_NEG: inj = ~s1;
      SGNJ_XOR: inj = s2 ^ s1;
      default:  inj = s2;
    endcase
  endfunction

  always_comb begin
    vd = vs2;
    case (execution_vector.bit_mode)
      BM_64: vd[63] = inj(execution_vector.sign_injection_mode, vs2[63], vs1[63]);
      BM_32: begin
        vd[63] = inj(execution_vector.sign_injection_mode, vs2[63], vs1[63]);
        vd[31] = inj(execution_vector.sign_injection_mode, vs2[31], vs1[31]);
      end
      default: vd = vs2;
    endcase
  end
endmodule

module vector_floating_point_sign_injection_sequencer
  import vfp_sgnj_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int VL_WIDTH   = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  execution_vector_t     req_execution_vector,
  input  logic [ADDR_WIDTH-1:0] req_vs2_base,
  input  logic [ADDR_WIDTH-1:0] req_vs1_base,
  input  logic [ADDR_WIDTH-1:0] req_vd_base,
  input  logic [VL_WIDTH-1:0]   req_vl,
  output logic                  rf_rd_en,
  output logic [ADDR_WIDTH-1:0] rf_rd_addr_vs2,
  output logic [ADDR_WIDTH-1:0] rf_rd_addr_vs1,
  input  logic [63:0]           rf_rd_data_vs2,
  input  logic [63:0]           rf_rd_data_vs1,
  output logic                  rf_wr_en,
  output logic [ADDR_WIDTH-1:0] rf_wr_addr,
  output logic [63:0]           rf_wr_data,
  output logic [1:0]            rf_wr_lane_mask,
  output logic                  busy,
  output logic                  done,
  output logic                  done_error
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [VL_WIDTH-1:0]   cnt_q, cnt_d;
  logic [VL_WIDTH-1:0]   beats_q, beats_d;
  logic [ADDR_WIDTH-1:0] vs2_base_q, vs1_base_q, vd_base_q;
  execution_vector_t     ev_q;
  logic                  odd32_q, err_q;
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [1:0]            mask_q, mask_d;
  logic                  hs, mode_ok, last_beat;
  logic [63:0]           unit_vd;

  assign hs        = req_valid & req_ready;
  assign mode_ok   = (req_execution_vector.sign_injection_mode inside {SGNJ_VS1, SGNJ_NEG, SGNJ_XOR}) &&
                     (req_execution_vector.bit_mode inside {BM_32, BM_64});
  assign last_beat = (cnt_q == beats_q - VL_WIDTH'(1));

  always_comb begin
    // 32-bit mode packs two elements per beat: ceil(vl/2).
    beats_d = (req_execution_vector.bit_mode == BM_64) ? req_vl :
              VL_WIDTH'(({1'b0, req_vl} + (VL_WIDTH+1)'(1)) >> 1);
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (hs) begin
        cnt_d   = '0;
        state_d = (!mode_ok || req_vl == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        cnt_d = cnt_q + VL_WIDTH'(1);
        if (last_beat) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    // Odd vl in 32-bit mode leaves the upper lane of the final beat empty.
    mask_d = '0;
    if (state_q == S_RUN) mask_d = (last_beat && odd32_q) ? 2'b01 : 2'b11;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      beats_q    <= '0;
      vs2_base_q <= '0;
      vs1_base_q <= '0;
      vd_base_q  <= '0;
      ev_q       <= '0;
      odd32_q    <= 1'b0;
      err_q      <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      mask_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= rf_rd_en;
      wr_addr_q <= vd_base_q + ADDR_WIDTH'(cnt_q);
      mask_q    <= mask_d;
      if (hs) begin
        beats_q    <= beats_d;
        vs2_base_q <= req_vs2_base;
        vs1_base_q <= req_vs1_base;
        vd_base_q  <= req_vd_base;
        ev_q       <= req_execution_vector;
        odd32_q    <= (req_execution_vector.bit_mode == BM_32) & req_vl[0];
        err_q      <= ~mode_ok;
      end
    end
  end

  vector_floating_point_sign_injection_unit u_unit (
    .execution_vector (ev_q),
    .vs2              (rf_rd_data_vs2),
    .vs1              (rf_rd_data_vs1),
    .vd               (unit_vd)
  );

  assign req_ready       = (state_q == S_IDLE);
  assign busy            = (state_q != S_IDLE);
  assign done            = (state_q == S_DONE);
  assign done_error      = done & err_q;
  assign rf_rd_en        = (state_q == S_RUN);
  assign rf_rd_addr_vs2  = vs2_base_q + ADDR_WIDTH'(cnt_q);
  assign rf_rd_addr_vs1  = vs1_base_q + ADDR_WIDTH'(cnt_q);
  assign rf_wr_en        = wr_en_q;
  assign rf_wr_addr      = wr_addr_q;
  // Gated so an undriven register file never leaks X onto the write bus.
  assign rf_wr_data      = wr_en_q ? unit_vd : '0;
  assign rf_wr_lane_mask = mask_q;
endmodule
